// File: rtl/dh_pkg.sv
// Shared widths, FSM state encoding and mod-multiply timing for the DH exponentiator.
package dh_pkg;

  localparam int unsigned DH_WIDTH = 32;
  localparam int unsigned DH_EXP_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RED,
    S_CHK,
    S_MUL,
    S_SQR,
    S_DONE
  } state_t;

  // Cycles from issuing a mod-multiply to its done pulse: one per bit plus the load cycle.
  function automatic int unsigned mm_cycles(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/dh_mod_mul.sv
// Bit-serial interleaved modular multiplier: prod = a*b mod p, MSB of b first.
// Requires a < p; b may be any value. done pulses WIDTH+1 cycles after start.
module dh_mod_mul
  import dh_pkg::*;
#(
  parameter int unsigned WIDTH = DH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  localparam int unsigned ITERS = mm_cycles(WIDTH) - 1;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);
  localparam int unsigned ACC_W = WIDTH + 2;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] t1;
  logic [ACC_W-1:0] t2;
  logic [ACC_W-1:0] t3;

  // One iteration: double, add a if the current b bit is set, then reduce (sum < 3p).
  always_comb begin
    p_ext = ACC_W'(p_q);
    t1    = {acc_q[ACC_W-2:0], 1'b0} + (b_q[WIDTH-1] ? ACC_W'(a_q) : '0);
    t2    = (t1 >= p_ext) ? (t1 - p_ext) : t1;
    t3    = (t2 >= p_ext) ? (t2 - p_ext) : t2;
  end

  // Operand capture, iteration counter and registered result/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      done  <= 1'b0;
      prod  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_q   <= a;
        b_q   <= b;
        p_q   <= p;
        acc_q <= '0;
        cnt_q <= CNT_W'(ITERS);
      end else if (cnt_q != '0) begin
        acc_q <= t3;
        b_q   <= b_q << 1;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          done <= 1'b1;
          prod <= t3[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/dh_mod_exp.sv
// Sequential modular exponentiator r = g^x mod p, LSB-first square-and-multiply.
// The next multiply is issued on the same edge its predecessor completes, so every
// modular product costs exactly WIDTH+1 cycles end to end.
module dh_mod_exp
  import dh_pkg::*;
#(
  parameter int unsigned WIDTH = DH_WIDTH,
  parameter int unsigned EXP_W = DH_EXP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g,
  input  logic [EXP_W-1:0] x,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] r
);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] g_q;
  logic [EXP_W-1:0] e_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] base_q;

  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic             mm_done;
  logic [WIDTH-1:0] mm_prod;

  logic [EXP_W-1:0] e_shr;

  assign e_shr = e_q >> 1;

  dh_mod_mul #(
    .WIDTH(WIDTH)
  ) u_mod_mul (
    .clk  (clk),
    .rst  (rst),
    .start(mm_start),
    .a    (mm_a),
    .b    (mm_b),
    .p    (p_q),
    .done (mm_done),
    .prod (mm_prod)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and mod-multiply operand mux; fresh products are forwarded straight in.
  always_comb begin
    state_d  = state_q;
    mm_start = 1'b0;
    mm_a     = '0;
    mm_b     = '0;
    case (state_q)
      S_IDLE: begin
        if (st) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (p_q == '0) begin
          state_d = S_DONE;
        end else begin
          mm_start = 1'b1;
          mm_a     = WIDTH'(1);
          mm_b     = g_q;
          state_d  = S_RED;
        end
      end
      S_RED: begin
        if (mm_done) begin
          state_d = S_CHK;
          if (e_q != '0) begin
            mm_start = 1'b1;
            mm_a     = e_q[0] ? res_q : mm_prod;
            mm_b     = mm_prod;
          end
        end
      end
      S_CHK: begin
        if (e_q == '0)  state_d = S_DONE;
        else if (e_q[0]) state_d = S_MUL;
        else             state_d = S_SQR;
      end
      S_MUL: begin
        if (mm_done) begin
          if (e_shr != '0) begin
            mm_start = 1'b1;
            mm_a     = base_q;
            mm_b     = base_q;
            state_d  = S_SQR;
          end else begin
            state_d = S_CHK;
          end
        end
      end
      S_SQR: begin
        if (mm_done) begin
          state_d = S_CHK;
          if (e_shr != '0) begin
            mm_start = 1'b1;
            mm_a     = e_shr[0] ? res_q : mm_prod;
            mm_b     = mm_prod;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latching, running result/base/exponent and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      g_q    <= '0;
      e_q    <= '0;
      res_q  <= '0;
      base_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      r      <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (st) begin
            p_q  <= p;
            g_q  <= g;
            e_q  <= x;
            busy <= 1'b1;
            err  <= 1'b0;
          end
        end
        S_LOAD: begin
          res_q <= (p_q == WIDTH'(1)) ? '0 : WIDTH'(1);
        end
        S_RED: begin
          if (mm_done) base_q <= mm_prod;
        end
        S_MUL: begin
          if (mm_done) begin
            res_q <= mm_prod;
            if (e_shr == '0) e_q <= '0;
          end
        end
        S_SQR: begin
          if (mm_done) begin
            base_q <= mm_prod;
            e_q    <= e_shr;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          err  <= (p_q == '0);
          r    <= (p_q == '0) ? '0 : res_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dh_mod_exp.sv
// Directed self-checking bench for dh_mod_exp: values, err flag and start-to-done latency.
module tb_dh_mod_exp;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [31:0] p;
  logic [31:0] g;
  logic [63:0] x;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] r;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  dh_mod_exp dut (
    .clk (clk),
    .rst (rst),
    .st  (st),
    .p   (p),
    .g   (g),
    .x   (x),
    .busy(busy),
    .done(done),
    .err (err),
    .r   (r)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference exponentiation using plain 64-bit remainder arithmetic.
  function automatic logic [31:0] ref_exp(input logic [31:0] gg, input logic [63:0] xx,
                                          input logic [31:0] pp);
    logic [63:0] rr;
    logic [63:0] bb;
    logic [63:0] pe;
    if (pp == 32'd0) return 32'd0;
    pe = {32'd0, pp};
    rr = 64'd1 % pe;
    bb = {32'd0, gg} % pe;
    for (int i = 0; i < 64; i++) begin
      if (xx[i]) rr = (rr * bb) % pe;
      bb = (bb * bb) % pe;
    end
    return rr[31:0];
  endfunction

  function automatic int lat_ref(input logic [63:0] xx);
    int m;
    m = 0;
    for (int i = 0; i < 64; i++) if (xx[i]) m = i;
    return 2 + 33 * (1 + $countones(xx) + m) + 1;
  endfunction

  task automatic start_op(input logic [31:0] gg, input logic [63:0] xx, input logic [31:0] pp);
    @(negedge clk);
    g  = gg;
    x  = xx;
    p  = pp;
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, output int lat);
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 6000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (done !== 1'b1) begin
      n_chk++;
      n_bad++;
      $display("FAIL %s_timeout: got=no_done exp=done", tag);
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic run(input string tag, input logic [31:0] gg, input logic [63:0] xx,
                     input logic [31:0] pp, input logic [31:0] exp_r, input logic exp_err,
                     input int exp_lat);
    int lat;
    start_op(gg, xx, pp);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(tag, lat);
    chk({tag, "_r"}, 64'(r), 64'(exp_r));
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    st  = 1'b0;
    g   = '0;
    x   = '0;
    p   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    rst = 1'b0;

    run("x6", 32'd5, 64'd6, 32'd23, 32'd8, 1'b0, 168);
    run("x15", 32'd5, 64'd15, 32'd23, 32'd19, 1'b0, 267);
    run("shared", 32'd19, 64'd6, 32'd23, 32'd2, 1'b0, 168);
    run("x0", 32'd5, 64'd0, 32'd23, 32'd1, 1'b0, 36);
    run("p1", 32'd7, 64'd3, 32'd1, 32'd0, 1'b0, 135);
    run("p0", 32'd9, 64'd5, 32'd0, 32'd0, 1'b1, 2);
    run("gbig", 32'd100, 64'd1, 32'd23, 32'd8, 1'b0, 69);
    run("large", 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFB,
        ref_exp(32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFB), 1'b0,
        lat_ref(64'hFFFF_FFFF_FFFF_FFFF));

    // Start re-asserted and inputs changed while busy.
    start_op(32'd5, 64'd6, 32'd23);
    repeat (5) @(negedge clk);
    st = 1'b1;
    g  = 32'd3;
    x  = 64'd7;
    p  = 32'd11;
    @(negedge clk);
    p  = 32'd0;
    x  = 64'd0;
    @(negedge clk);
    st = 1'b0;
    wait_done("busy_st", lat);
    chk("busy_st_r", 64'(r), 64'd8);
    chk("busy_st_lat", 64'(lat), 64'd168);

    // Start held high: restarts as soon as IDLE is reached.
    @(negedge clk);
    g  = 32'd5;
    x  = 64'd0;
    p  = 32'd23;
    st = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    wait_done("hold1", lat);
    chk("hold1_r", 64'(r), 64'd1);
    chk("hold1_lat", 64'(lat), 64'd36);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    st = 1'b0;
    chk("hold2_busy", 64'(busy), 64'd1);
    wait_done("hold2", lat);
    chk("hold2_lat", 64'(lat), 64'd36);

    // Reset pulsed while in the first multiply, then a fresh run.
    run("pre_rst", 32'd5, 64'd6, 32'd23, 32'd8, 1'b0, 168);
    start_op(32'd5, 64'd6, 32'd23);
    repeat (74) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_r", 64'(r), 64'd0);
    rst = 1'b0;
    run("after_rst", 32'd5, 64'd15, 32'd23, 32'd19, 1'b0, 267);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
